// File: rtl/axi_lite_arbiter_if.sv
// AXI4-Lite payload types and the AXI4-Lite interface used by axi_lite_arbiter.
//   axi_lite_pkg : ADDR_W/DATA_W widths and addr_t/data_t/resp_t.
//   axi_lite_if  : AW/W/B/AR/R channels, no WSTRB/PROT.
//     modport master : drives awaddr/awvalid/wdata/wvalid/bready/araddr/arvalid/rready
//     modport slave  : drives awready/wready/bresp/bvalid/arready/rdata/rresp/rvalid
package axi_lite_pkg;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned RESP_W = 2;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [DATA_W-1:0] data_t;
  typedef logic [RESP_W-1:0] resp_t;
endpackage

interface axi_lite_if;
  import axi_lite_pkg::*;

  addr_t awaddr;
  logic  awvalid;
  logic  awready;
  data_t wdata;
  logic  wvalid;
  logic  wready;
  resp_t bresp;
  logic  bvalid;
  logic  bready;
  addr_t araddr;
  logic  arvalid;
  logic  arready;
  data_t rdata;
  resp_t rresp;
  logic  rvalid;
  logic  rready;

  modport master (
    output awaddr, awvalid, wdata, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axi_lite_arbiter.sv
// Two-master to one-slave AXI4-Lite arbiter with independent round-robin
// write and read arbitration.
// Ports:
//   clk          single clock, rising edge
//   rst          synchronous active-low reset
//   s0_axi_lite  upstream master 0 (slave modport)
//   s1_axi_lite  upstream master 1 (slave modport)
//   m_axi_lite   shared downstream slave (master modport)
//   wr_grant     one-hot write owner, 0 = none
//   rd_grant     one-hot read owner, 0 = none
//   timeout_err  one-cycle pulse on response watchdog expiry
// Optional feature: define AXIL_ARB_TIMEOUT_EN to enable the response-phase
// watchdog (limit = TIMEOUT cycles). Without it timeout_err is tied 0.
module axi_lite_arbiter
  import axi_lite_pkg::*;
#(
  parameter int unsigned TIMEOUT = 256
) (
  input  logic       clk,
  input  logic       rst,
  axi_lite_if.slave  s0_axi_lite,
  axi_lite_if.slave  s1_axi_lite,
  axi_lite_if.master m_axi_lite,
  output logic [1:0] wr_grant,
  output logic [1:0] rd_grant,
  output logic       timeout_err
);

  localparam resp_t RESP_SLVERR = 2'b10;

  // Elaboration guard: a zero limit would make the watchdog meaningless.
  if (TIMEOUT == 0) begin : g_timeout_chk
    $error("axi_lite_arbiter: TIMEOUT must be at least 1");
  end

  typedef enum logic [1:0] {W_IDLE = 2'd0, W_ADDR = 2'd1, W_RESP = 2'd2} w_state_t;
  typedef enum logic [1:0] {R_IDLE = 2'd0, R_ADDR = 2'd1, R_DATA = 2'd2} r_state_t;

  // ---------------------------------------------------------------------------
  // Write channel state
  // ---------------------------------------------------------------------------
  w_state_t   w_state, w_state_n;
  logic       w_owner, w_owner_n;
  logic       w_last, w_last_n;
  logic [1:0] wr_grant_n;
  logic       aw_done, aw_done_n;
  logic       w_done, w_done_n;

  // Watchdog status (constant 0 when the watchdog is compiled out)
  logic       w_to, w_drain;
  logic       r_to, r_drain;

  logic [1:0] w_req;
  logic       w_pick;
  addr_t      own_awaddr;
  logic       own_awvalid;
  data_t      own_wdata;
  logic       own_wvalid;
  logic       own_bready;
  logic       w_addr_ph, w_resp_ph, w_idle_ph;
  logic       m_awvalid_c, m_wvalid_c;
  logic       awready_c, wready_c;
  logic       aw_fire, w_fire;
  logic       bvalid_c, b_fire;
  resp_t      bresp_c;

  assign w_req[0] = s0_axi_lite.awvalid & s0_axi_lite.wvalid;
  assign w_req[1] = s1_axi_lite.awvalid & s1_axi_lite.wvalid;
  // Tie goes to the master that was not served last
  assign w_pick   = (&w_req) ? ~w_last : w_req[1];

  assign w_idle_ph = (w_state == W_IDLE);
  assign w_addr_ph = (w_state == W_ADDR);
  assign w_resp_ph = (w_state == W_RESP);

  // Owner-side source mux
  assign own_awaddr  = w_owner ? s1_axi_lite.awaddr  : s0_axi_lite.awaddr;
  assign own_awvalid = w_owner ? s1_axi_lite.awvalid : s0_axi_lite.awvalid;
  assign own_wdata   = w_owner ? s1_axi_lite.wdata   : s0_axi_lite.wdata;
  assign own_wvalid  = w_owner ? s1_axi_lite.wvalid  : s0_axi_lite.wvalid;
  assign own_bready  = w_owner ? s1_axi_lite.bready  : s0_axi_lite.bready;

  // Each address/data valid is withdrawn as soon as its own handshake is done
  assign m_awvalid_c = w_addr_ph & ~aw_done & own_awvalid;
  assign m_wvalid_c  = w_addr_ph & ~w_done & own_wvalid;
  assign awready_c   = w_addr_ph & ~aw_done & m_axi_lite.awready;
  assign wready_c    = w_addr_ph & ~w_done & m_axi_lite.wready;
  assign aw_fire     = m_awvalid_c & m_axi_lite.awready;
  assign w_fire      = m_wvalid_c & m_axi_lite.wready;

  // After a watchdog expiry the owner gets a locally generated SLVERR
  assign bvalid_c = w_resp_ph & (m_axi_lite.bvalid | w_to);
  assign bresp_c  = w_to ? RESP_SLVERR : m_axi_lite.bresp;
  assign b_fire   = bvalid_c & own_bready;

  assign m_axi_lite.awaddr  = own_awaddr;
  assign m_axi_lite.awvalid = m_awvalid_c;
  assign m_axi_lite.wdata   = own_wdata;
  assign m_axi_lite.wvalid  = m_wvalid_c;
  // Stray late B is drained in W_IDLE after a timeout
  assign m_axi_lite.bready  = (w_resp_ph & own_bready & ~w_to) | (w_idle_ph & w_drain);

  assign s0_axi_lite.awready = awready_c & ~w_owner;
  assign s1_axi_lite.awready = awready_c & w_owner;
  assign s0_axi_lite.wready  = wready_c & ~w_owner;
  assign s1_axi_lite.wready  = wready_c & w_owner;
  assign s0_axi_lite.bvalid  = bvalid_c & ~w_owner;
  assign s1_axi_lite.bvalid  = bvalid_c & w_owner;
  assign s0_axi_lite.bresp   = bresp_c;
  assign s1_axi_lite.bresp   = bresp_c;

  // Write FSM state register
  always_ff @(posedge clk) begin
    if (!rst) begin
      w_state  <= W_IDLE;
      w_owner  <= 1'b0;
      w_last   <= 1'b1;
      wr_grant <= 2'b00;
      aw_done  <= 1'b0;
      w_done   <= 1'b0;
    end else begin
      w_state  <= w_state_n;
      w_owner  <= w_owner_n;
      w_last   <= w_last_n;
      wr_grant <= wr_grant_n;
      aw_done  <= aw_done_n;
      w_done   <= w_done_n;
    end
  end

  // Write FSM next state
  always_comb begin
    w_state_n  = w_state;
    w_owner_n  = w_owner;
    w_last_n   = w_last;
    wr_grant_n = wr_grant;
    aw_done_n  = aw_done;
    w_done_n   = w_done;
    unique case (w_state)
      W_IDLE: begin
        if ((|w_req) && !w_drain) begin
          w_state_n  = W_ADDR;
          w_owner_n  = w_pick;
          wr_grant_n = w_pick ? 2'b10 : 2'b01;
        end
      end
      W_ADDR: begin
        aw_done_n = aw_done | aw_fire;
        w_done_n  = w_done | w_fire;
        // Both flags registered: response phase starts the cycle after
        if (aw_done && w_done) begin
          w_state_n = W_RESP;
          aw_done_n = 1'b0;
          w_done_n  = 1'b0;
        end
      end
      W_RESP: begin
        if (b_fire) begin
          w_state_n  = W_IDLE;
          w_last_n   = w_owner;
          wr_grant_n = 2'b00;
        end
      end
      default: begin
        w_state_n  = W_IDLE;
        wr_grant_n = 2'b00;
        aw_done_n  = 1'b0;
        w_done_n   = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Read channel state
  // ---------------------------------------------------------------------------
  r_state_t   r_state, r_state_n;
  logic       r_owner, r_owner_n;
  logic       r_last, r_last_n;
  logic [1:0] rd_grant_n;

  logic [1:0] r_req;
  logic       r_pick;
  addr_t      own_araddr;
  logic       own_arvalid;
  logic       own_rready;
  logic       r_idle_ph, r_addr_ph, r_data_ph;
  logic       m_arvalid_c, arready_c, ar_fire;
  logic       rvalid_c, r_fire;
  data_t      rdata_c;
  resp_t      rresp_c;

  assign r_req[0] = s0_axi_lite.arvalid;
  assign r_req[1] = s1_axi_lite.arvalid;
  assign r_pick   = (&r_req) ? ~r_last : r_req[1];

  assign r_idle_ph = (r_state == R_IDLE);
  assign r_addr_ph = (r_state == R_ADDR);
  assign r_data_ph = (r_state == R_DATA);

  assign own_araddr  = r_owner ? s1_axi_lite.araddr  : s0_axi_lite.araddr;
  assign own_arvalid = r_owner ? s1_axi_lite.arvalid : s0_axi_lite.arvalid;
  assign own_rready  = r_owner ? s1_axi_lite.rready  : s0_axi_lite.rready;

  assign m_arvalid_c = r_addr_ph & own_arvalid;
  assign arready_c   = r_addr_ph & m_axi_lite.arready;
  assign ar_fire     = m_arvalid_c & m_axi_lite.arready;

  assign rvalid_c = r_data_ph & (m_axi_lite.rvalid | r_to);
  assign rdata_c  = r_to ? '0 : m_axi_lite.rdata;
  assign rresp_c  = r_to ? RESP_SLVERR : m_axi_lite.rresp;
  assign r_fire   = rvalid_c & own_rready;

  assign m_axi_lite.araddr  = own_araddr;
  assign m_axi_lite.arvalid = m_arvalid_c;
  assign m_axi_lite.rready  = (r_data_ph & own_rready & ~r_to) | (r_idle_ph & r_drain);

  assign s0_axi_lite.arready = arready_c & ~r_owner;
  assign s1_axi_lite.arready = arready_c & r_owner;
  assign s0_axi_lite.rvalid  = rvalid_c & ~r_owner;
  assign s1_axi_lite.rvalid  = rvalid_c & r_owner;
  assign s0_axi_lite.rdata   = rdata_c;
  assign s1_axi_lite.rdata   = rdata_c;
  assign s0_axi_lite.rresp   = rresp_c;
  assign s1_axi_lite.rresp   = rresp_c;

  // Read FSM state register
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state  <= R_IDLE;
      r_owner  <= 1'b0;
      r_last   <= 1'b1;
      rd_grant <= 2'b00;
    end else begin
      r_state  <= r_state_n;
      r_owner  <= r_owner_n;
      r_last   <= r_last_n;
      rd_grant <= rd_grant_n;
    end
  end

  // Read FSM next state
  always_comb begin
    r_state_n  = r_state;
    r_owner_n  = r_owner;
    r_last_n   = r_last;
    rd_grant_n = rd_grant;
    unique case (r_state)
      R_IDLE: begin
        if ((|r_req) && !r_drain) begin
          r_state_n  = R_ADDR;
          r_owner_n  = r_pick;
          rd_grant_n = r_pick ? 2'b10 : 2'b01;
        end
      end
      R_ADDR: begin
        if (ar_fire) begin
          r_state_n = R_DATA;
        end
      end
      R_DATA: begin
        if (r_fire) begin
          r_state_n  = R_IDLE;
          r_last_n   = r_owner;
          rd_grant_n = 2'b00;
        end
      end
      default: begin
        r_state_n  = R_IDLE;
        rd_grant_n = 2'b00;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Response-phase watchdog
  // ---------------------------------------------------------------------------
`ifdef AXIL_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [CNT_W-1:0] w_cnt, r_cnt;

  // Counts response-phase cycles without a downstream valid; on expiry the
  // owner is answered locally and the real response is drained later.
  always_ff @(posedge clk) begin
    if (!rst) begin
      w_cnt       <= '0;
      r_cnt       <= '0;
      w_to        <= 1'b0;
      r_to        <= 1'b0;
      w_drain     <= 1'b0;
      r_drain     <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      timeout_err <= 1'b0;

      if (w_resp_ph) begin
        if (b_fire) begin
          w_cnt   <= '0;
          w_to    <= 1'b0;
          w_drain <= w_to;
        end else if (!w_to && !m_axi_lite.bvalid) begin
          if (w_cnt == CNT_W'(TIMEOUT - 1)) begin
            w_to        <= 1'b1;
            timeout_err <= 1'b1;
          end else begin
            w_cnt <= w_cnt + CNT_W'(1);
          end
        end
      end else if (w_idle_ph && w_drain && m_axi_lite.bvalid) begin
        w_drain <= 1'b0;
      end

      if (r_data_ph) begin
        if (r_fire) begin
          r_cnt   <= '0;
          r_to    <= 1'b0;
          r_drain <= r_to;
        end else if (!r_to && !m_axi_lite.rvalid) begin
          if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
            r_to        <= 1'b1;
            timeout_err <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
      end else if (r_idle_ph && r_drain && m_axi_lite.rvalid) begin
        r_drain <= 1'b0;
      end
    end
  end
`else
  assign w_to        = 1'b0;
  assign w_drain     = 1'b0;
  assign r_to        = 1'b0;
  assign r_drain     = 1'b0;
  assign timeout_err = 1'b0;
`endif

endmodule
